// File: rtl/fault_injection_engine_if.sv
// Streaming handshake bundle for the fault injection engine.
//   in_valid/in_ready/in_code       : upstream codeword stream into the engine
//   out_valid/out_ready/out_code    : downstream (possibly corrupted) stream
//   inj_flag                        : sideband qualifying out_code as an injection event
// slave  : the engine side (consumes in_*, produces out_*)
// master : the encoder/checker side (bench or surrounding fabric)
interface fault_injection_engine_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_code;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_code;
    logic             inj_flag;

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_code, inj_flag
    );

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_code, inj_flag
    );
endinterface

// File: rtl/fault_injection_engine.sv
// Streaming fault injector between a codeword encoder and its checker.
// Words flow through a single output register (latency 1). While a campaign
// is ARMED, every Nth accepted word is corrupted with the latched mode/mask
// (optionally ANDed with an LFSR) and tagged with inj_flag.
// Ports:
//   clk, rst_n           clock / async active-low reset
//   bus (slave)          in_* / out_* valid-ready streams plus inj_flag
//   cfg_mode             00 none, 01 set bits, 10 clear bits, 11 flip bits
//   cfg_mask, cfg_rand   eligible bits; rand=1 ANDs mask with lfsr[WIDTH-1:0]
//   cfg_period           inject every Nth accepted word (0 behaves as 1)
//   cfg_count            injections before stopping (0 = unlimited)
//   arm                  pulse: latch cfg_*, reset counters/LFSR, enter ARMED
//   busy, inj_total      campaign active / saturating injection count
module fault_injection_engine #(
    parameter int          WIDTH     = 12,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fault_injection_engine_if.slave bus,
    input  logic [1:0]           cfg_mode,
    input  logic [WIDTH-1:0]     cfg_mask,
    input  logic                 cfg_rand,
    input  logic [CNT_W-1:0]     cfg_period,
    input  logic [CNT_W-1:0]     cfg_count,
    input  logic                 arm,
    output logic                 busy,
    output logic [CNT_W-1:0]     inj_total
);
    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [31:0] SEED = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]       mode_q;
    logic [WIDTH-1:0] mask_q;
    logic             rand_q;
    logic [CNT_W-1:0] period_q;
    logic             cnt_en_q;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] total_q;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_nxt;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_code_q;
    logic             inj_flag_q;

    logic             accept;
    logic             inj_event;
    logic [WIDTH-1:0] eff_mask;
    logic [WIDTH-1:0] corrupted;
    logic [CNT_W-1:0] period_eff;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = out_code_q;
    assign bus.inj_flag  = inj_flag_q;
    assign busy          = (state == ARMED);
    assign inj_total     = total_q;

    assign accept     = bus.in_valid && bus.in_ready;
    assign period_eff = (cfg_period == '0) ? CNT_W'(1) : cfg_period;
    // The arm cycle itself never injects: the word passes through untouched.
    assign inj_event  = (state == ARMED) && accept && !arm && (pcnt == CNT_W'(1));
    // The mask uses the LFSR value before this word's advance.
    assign eff_mask   = rand_q ? (lfsr[WIDTH-1:0] & mask_q) : mask_q;
    assign lfsr_nxt   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);

    always_comb begin
        corrupted = bus.in_code;
        case (mode_q)
            2'b01:   corrupted = bus.in_code | eff_mask;
            2'b10:   corrupted = bus.in_code & ~eff_mask;
            2'b11:   corrupted = bus.in_code ^ eff_mask;
            default: corrupted = bus.in_code;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (arm)
            state_nxt = ARMED;
        else if (inj_event && cnt_en_q && remaining == CNT_W'(1))
            state_nxt = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            inj_flag_q  <= 1'b0;
            mode_q      <= 2'b00;
            mask_q      <= '0;
            rand_q      <= 1'b0;
            period_q    <= '0;
            cnt_en_q    <= 1'b0;
            pcnt        <= '0;
            remaining   <= '0;
            total_q     <= '0;
            lfsr        <= SEED;
        end else begin
            // Output register: load on accept, drain when consumed, else hold.
            if (accept) begin
                out_code_q  <= inj_event ? corrupted : bus.in_code;
                inj_flag_q  <= inj_event;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (arm) begin
                mode_q    <= cfg_mode;
                mask_q    <= cfg_mask;
                rand_q    <= cfg_rand;
                period_q  <= period_eff;
                cnt_en_q  <= (cfg_count != '0);
                pcnt      <= period_eff;
                remaining <= cfg_count;
                total_q   <= '0;
                lfsr      <= SEED;
            end else if (state == ARMED && accept) begin
                lfsr <= lfsr_nxt;
                if (pcnt == CNT_W'(1)) begin
                    pcnt <= period_q;
                    if (total_q != '1) total_q <= total_q + CNT_W'(1);
                    if (cnt_en_q)      remaining <= remaining - CNT_W'(1);
                end else begin
                    pcnt <= pcnt - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fault_injection_engine.sv
module tb_fault_injection_engine;
    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic        gclk;
    logic        grst_n;
    logic [1:0]  cfg_mode;
    logic [11:0] cfg_mask;
    logic        cfg_rand;
    logic [15:0] cfg_period;
    logic [15:0] cfg_count;
    logic        arm;
    logic        busy;
    logic [15:0] inj_total;

    int n_chk  = 0;
    int n_fail = 0;
    logic [12:0] sb[$];   // {flag, code}

    logic [31:0] m_lfsr;
    logic [15:0] m_pcnt;

    fault_injection_engine_if #(.WIDTH(12)) bus ();

    fault_injection_engine #(.WIDTH(12), .CNT_W(16), .LFSR_SEED(SEED)) dut (
        .clk        (gclk),
        .rst_n      (grst_n),
        .bus        (bus),
        .cfg_mode   (cfg_mode),
        .cfg_mask   (cfg_mask),
        .cfg_rand   (cfg_rand),
        .cfg_period (cfg_period),
        .cfg_count  (cfg_count),
        .arm        (arm),
        .busy       (busy),
        .inj_total  (inj_total)
    );

    initial begin
        gclk = 1'b0;
        forever #5 gclk = ~gclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'd0);
    endfunction

    // Scoreboard consumer: compare every word the DUT hands downstream.
    always @(negedge gclk) begin
        if (grst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {19'd0, bus.inj_flag, bus.out_code}, 32'hFFFF_FFFF);
            end else begin
                logic [12:0] e;
                e = sb.pop_front();
                chk("out_code", {20'd0, bus.out_code}, {20'd0, e[11:0]});
                chk("inj_flag", {31'd0, bus.inj_flag}, {31'd0, e[12]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    // Drivers start and end at posedge+1.
    task automatic send(input logic [11:0] c, input logic [11:0] ec, input logic ef);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_code  = c;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge gclk);
            if (bus.in_ready) begin
                sb.push_back({ef, ec});
                ok = 1;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge gclk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_arm(input logic [1:0] md, input logic [11:0] mk, input logic rn,
                          input logic [15:0] pr, input logic [15:0] ct);
        cfg_mode = md; cfg_mask = mk; cfg_rand = rn; cfg_period = pr; cfg_count = ct;
        arm = 1'b1;
        @(posedge gclk); #1;
        arm = 1'b0;
        m_lfsr = SEED;
        m_pcnt = (pr == 0) ? 16'd1 : pr;
    endtask

    task automatic drain;
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge gclk);
        #1;
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    // Random-mask flip word driven through the bench LFSR/period model.
    task automatic send_rand_flip(input logic [15:0] pr);
        logic [11:0] d;
        d = 12'($urandom);
        if (m_pcnt == 16'd1) begin
            send(d, d ^ m_lfsr[11:0], 1'b1);
            m_pcnt = pr;
        end else begin
            send(d, d, 1'b0);
            m_pcnt = m_pcnt - 16'd1;
        end
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    initial begin
        grst_n = 1'b0;
        arm = 1'b0; cfg_mode = 2'b00; cfg_mask = '0; cfg_rand = 1'b0;
        cfg_period = '0; cfg_count = '0;
        bus.in_valid = 1'b0; bus.in_code = '0; bus.out_ready = 1'b1;
        m_lfsr = SEED; m_pcnt = 16'd1;
        #23;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_code",  {20'd0, bus.out_code}, 32'd0);
        chk("rst_inj_flag",  {31'd0, bus.inj_flag}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_inj_total", {16'd0, inj_total}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        @(posedge gclk); #1;
        grst_n = 1'b1;
        @(posedge gclk); #1;

        // T1: idle passthrough
        send(12'hABC, 12'hABC, 1'b0);
        drain();

        // T2: set low nibble, three injections then DONE
        do_arm(2'b01, 12'h00F, 1'b0, 16'd1, 16'd3);
        chk("t2_busy_armed", {31'd0, busy}, 32'd1);
        send(12'h000, 12'h00F, 1'b1);
        send(12'h000, 12'h00F, 1'b1);
        chk("t2_busy_mid", {31'd0, busy}, 32'd1);
        send(12'h000, 12'h00F, 1'b1);
        chk("t2_busy_done", {31'd0, busy}, 32'd0);
        send(12'h000, 12'h000, 1'b0);
        drain();
        chk("t2_inj_total", {16'd0, inj_total}, 32'd3);

        // T3: clear high nibble every 3rd word, unlimited; cfg edits ignored
        do_arm(2'b10, 12'hF00, 1'b0, 16'd3, 16'd0);
        cfg_mode = 2'b11; cfg_mask = 12'hFFF; cfg_period = 16'd1;
        for (int i = 1; i <= 6; i++)
            send(12'hFFF, (i % 3 == 0) ? 12'h0FF : 12'hFFF, (i % 3 == 0));
        drain();
        chk("t3_busy", {31'd0, busy}, 32'd1);
        chk("t3_inj_total", {16'd0, inj_total}, 32'd2);

        // T4: T3 with a 5-cycle downstream stall mid-stream
        do_arm(2'b10, 12'hF00, 1'b0, 16'd3, 16'd0);
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send(12'hFFF, (i % 3 == 0) ? 12'h0FF : 12'hFFF, (i % 3 == 0));
            end
            begin
                logic [11:0] held;
                repeat (3) @(posedge gclk);
                #1 bus.out_ready = 1'b0;
                @(negedge gclk);
                held = bus.out_code;
                chk("t4_stall_valid", {31'd0, bus.out_valid}, 32'd1);
                for (int n = 0; n < 4; n++) begin
                    @(negedge gclk);
                    chk("t4_stall_code", {20'd0, bus.out_code}, {20'd0, held});
                    chk("t4_stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
                end
                @(posedge gclk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("t4_inj_total", {16'd0, inj_total}, 32'd2);

        // T5: LFSR-masked flips every 2nd word
        do_arm(2'b11, 12'hFFF, 1'b1, 16'd2, 16'd0);
        for (int i = 0; i < 20; i++) send_rand_flip(16'd2);
        drain();
        chk("t5_inj_total", {16'd0, inj_total}, 32'd10);

        // T6: async reset mid-campaign with a word parked in the output
        do_arm(2'b11, 12'hFFF, 1'b1, 16'd2, 16'd0);
        for (int i = 0; i < 3; i++) send_rand_flip(16'd2);
        bus.out_ready = 1'b0;
        @(posedge gclk); #3;
        chk("t6_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        grst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_rst_code",  {20'd0, bus.out_code}, 32'd0);
        chk("t6_rst_flag",  {31'd0, bus.inj_flag}, 32'd0);
        chk("t6_rst_busy",  {31'd0, busy}, 32'd0);
        chk("t6_rst_total", {16'd0, inj_total}, 32'd0);
        sb.delete();
        @(posedge gclk); #1;
        grst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(12'h123, 12'h123, 1'b0);
        drain();
        do_arm(2'b11, 12'hFFF, 1'b1, 16'd2, 16'd0);
        for (int i = 0; i < 6; i++) send_rand_flip(16'd2);
        drain();
        chk("t6_inj_total", {16'd0, inj_total}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
